// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN = 16;

    localparam logic [XLEN-1:0] FETCH_NOP_INST    = 16'h0800;
    localparam logic [XLEN-1:0] FETCH_RESET_PC    = 16'h0000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT   = 3'd2,
        HOLD   = 3'd3,
        HALTED = 3'd4,
        ERROR  = 3'd5
    } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Generic XLEN-bit register with async active-high reset to a chosen value and a load enable.
module pc_reg
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [XLEN-1:0] d,
    output logic [XLEN-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one instruction per PC through a
// stallable memory handshake and hands it to execute until it is retired.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = FETCH_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INST = FETCH_NOP_INST
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] PC_next,
    input  logic            pc_load,
    input  logic            stall,
    input  logic            halt,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_stall,
    input  logic            imem_done,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] PC_old,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst_count,
    output logic            halted,
    output logic            err
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;

    logic            take_halt;
    logic            load_ok;
    logic            retire;
    logic            misalign;
    logic            capture;
    logic            inst_load;
    logic [XLEN-1:0] inst_d;
    logic [XLEN-1:0] count_d;

    // Halt outranks retire; a stalled retire is simply not taken.
    always_comb begin
        take_halt = (state_q == HOLD) && halt;
        load_ok   = (state_q == HOLD) && !halt && pc_load && !stall;
        retire    = load_ok && !PC_next[0];
        misalign  = load_ok && PC_next[0];
        capture   = (state_q == WAIT) && imem_done;
        inst_load = capture || retire || take_halt || misalign;
        inst_d    = capture ? imem_rdata : NOP_INST;
        count_d   = inst_count + XLEN'(1);
    end

    pc_reg #(.RESET_VAL(RESET_PC)) u_pc (
        .clk  (clk),
        .rst  (rst),
        .load (retire),
        .d    (PC_next),
        .q    (pc_q)
    );

    pc_reg #(.RESET_VAL(NOP_INST)) u_inst (
        .clk  (clk),
        .rst  (rst),
        .load (inst_load),
        .d    (inst_d),
        .q    (inst)
    );

    pc_reg #(.RESET_VAL(XLEN'(0))) u_count (
        .clk  (clk),
        .rst  (rst),
        .load (retire),
        .d    (count_d),
        .q    (inst_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            inst_valid <= 1'b0;
            halted     <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: state_q <= REQ;
                REQ: begin
                    if (!imem_stall) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_done) begin
                        inst_valid <= 1'b1;
                        state_q    <= HOLD;
                    end
                end
                HOLD: begin
                    if (take_halt) begin
                        halted     <= 1'b1;
                        inst_valid <= 1'b0;
                        state_q    <= HALTED;
                    end else if (misalign) begin
                        err        <= 1'b1;
                        inst_valid <= 1'b0;
                        state_q    <= ERROR;
                    end else if (retire) begin
                        inst_valid <= 1'b0;
                        state_q    <= REQ;
                    end
                end
                HALTED:  state_q <= HALTED;
                ERROR:   state_q <= ERROR;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Request and address are decoded straight from state and PC.
    assign imem_req  = (state_q == REQ);
    assign imem_addr = pc_q;
    assign PC_old    = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scoreboard bench for fetch_unit: fetched words are queued when a request is
// accepted and compared when the instruction shows up on inst/PC_old.
module tb_fetch_unit;

    localparam logic [15:0] NOP = 16'h0800;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] PC_next;
    logic        pc_load;
    logic        stall;
    logic        halt;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_stall;
    logic        imem_done;
    logic [15:0] imem_rdata;
    logic [15:0] inst;
    logic [15:0] PC_old;
    logic        inst_valid;
    logic [15:0] inst_count;
    logic        halted;
    logic        err;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .PC_next    (PC_next),
        .pc_load    (pc_load),
        .stall      (stall),
        .halt       (halt),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_stall (imem_stall),
        .imem_done  (imem_done),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .PC_old     (PC_old),
        .inst_valid (inst_valid),
        .inst_count (inst_count),
        .halted     (halted),
        .err        (err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'h4123;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for imem_req, then serves one read with the given stall/delay profile.
    task automatic do_fetch(input logic [15:0] pc, input int nstall, input int ndelay,
                            input int exp_wait);
        int   waited;
        exp_t e;
        waited = 0;
        while (!imem_req && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("req_seen", 16'(imem_req), 16'd1);
        if (exp_wait >= 0) check("req_latency", 16'(waited), 16'(exp_wait));
        check("req_addr", imem_addr, pc);
        sb.push_back('{pc: pc, data: mem_word(pc)});
        for (int i = 0; i < nstall; i++) begin
            imem_stall = 1'b1;
            @(negedge clk);
            check("stall_req", 16'(imem_req), 16'd1);
            check("stall_addr", imem_addr, pc);
        end
        imem_stall = 1'b0;
        @(negedge clk);
        check("wait_req", 16'(imem_req), 16'd0);
        for (int i = 0; i < ndelay; i++) begin
            @(negedge clk);
            check("wait_valid", 16'(inst_valid), 16'd0);
        end
        imem_done  = 1'b1;
        imem_rdata = mem_word(imem_addr);
        @(negedge clk);
        imem_done  = 1'b0;
        imem_rdata = 16'hDEAD;
        check("hold_valid", 16'(inst_valid), 16'd1);
        if (sb.size() == 0) begin
            check("sb_empty", 16'(sb.size()), 16'd1);
        end else begin
            e = sb.pop_front();
            check("hold_inst", inst, e.data);
            check("hold_pc", PC_old, e.pc);
        end
    endtask

    task automatic retire(input logic [15:0] nxt, input logic [15:0] exp_count);
        PC_next = nxt;
        pc_load = 1'b1;
        @(negedge clk);
        pc_load = 1'b0;
        check("ret_valid", 16'(inst_valid), 16'd0);
        check("ret_inst", inst, NOP);
        check("ret_count", inst_count, exp_count);
        check("ret_pc", PC_old, nxt);
        check("ret_req", 16'(imem_req), 16'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        PC_next    = 16'h0000;
        pc_load    = 1'b0;
        stall      = 1'b0;
        halt       = 1'b0;
        imem_stall = 1'b0;
        imem_done  = 1'b0;
        imem_rdata = 16'h0000;
        repeat (2) @(negedge clk);
        check("rst_req", 16'(imem_req), 16'd0);
        check("rst_inst", inst, NOP);
        check("rst_pc", PC_old, 16'h0000);
        check("rst_valid", 16'(inst_valid), 16'd0);
        check("rst_count", inst_count, 16'd0);
        check("rst_halted", 16'(halted), 16'd0);
        check("rst_err", 16'(err), 16'd0);
        rst = 1'b0;
        check("idle_req", 16'(imem_req), 16'd0);

        // Zero-wait fetch after reset, then retire and a stalled/delayed fetch.
        do_fetch(16'h0000, 0, 0, 1);
        retire(16'h0002, 16'd1);
        do_fetch(16'h0002, 3, 4, 0);

        // Retire blocked by a downstream stall.
        stall   = 1'b1;
        pc_load = 1'b1;
        PC_next = 16'h0040;
        repeat (2) begin
            @(negedge clk);
            check("stall_pc", PC_old, 16'h0002);
            check("stall_inst", inst, mem_word(16'h0002));
            check("stall_valid", 16'(inst_valid), 16'd1);
        end
        pc_load = 1'b0;
        stall   = 1'b0;
        check("stall_count", inst_count, 16'd1);

        // PC wrap-around from FFFE to 0000.
        retire(16'hFFFE, 16'd2);
        do_fetch(16'hFFFE, 0, 1, 0);
        retire(16'h0000, 16'd3);
        do_fetch(16'h0000, 1, 0, 0);

        // Halt takes priority over a simultaneous retire.
        halt    = 1'b1;
        pc_load = 1'b1;
        PC_next = 16'h0010;
        @(negedge clk);
        halt    = 1'b0;
        pc_load = 1'b0;
        check("halt_halted", 16'(halted), 16'd1);
        check("halt_valid", 16'(inst_valid), 16'd0);
        check("halt_inst", inst, NOP);
        check("halt_pc", PC_old, 16'h0000);
        check("halt_count", inst_count, 16'd3);
        repeat (3) begin
            @(negedge clk);
            check("halt_noreq", 16'(imem_req), 16'd0);
        end

        // Misaligned PC from execute.
        do_reset();
        check("rst2_halted", 16'(halted), 16'd0);
        do_fetch(16'h0000, 0, 0, 1);
        PC_next = 16'h0013;
        pc_load = 1'b1;
        @(negedge clk);
        pc_load = 1'b0;
        check("mis_err", 16'(err), 16'd1);
        check("mis_valid", 16'(inst_valid), 16'd0);
        check("mis_pc", PC_old, 16'h0000);
        check("mis_count", inst_count, 16'd0);
        repeat (3) begin
            @(negedge clk);
            check("mis_noreq", 16'(imem_req), 16'd0);
            check("mis_sticky", 16'(err), 16'd1);
        end

        // Reset while a read is outstanding; a stray response afterwards is ignored.
        do_reset();
        check("rst3_err", 16'(err), 16'd0);
        do_fetch(16'h0000, 0, 0, 1);
        retire(16'h0024, 16'd1);
        @(negedge clk);
        check("mid_wait", 16'(imem_req), 16'd0);
        rst = 1'b1;
        #1;
        check("mid_pc", PC_old, 16'h0000);
        check("mid_valid", 16'(inst_valid), 16'd0);
        check("mid_count", inst_count, 16'd0);
        @(negedge clk);
        rst        = 1'b0;
        imem_done  = 1'b1;
        imem_rdata = 16'hBEEF;
        @(negedge clk);
        imem_done  = 1'b0;
        check("stray_valid", 16'(inst_valid), 16'd0);
        check("stray_inst", inst, NOP);
        do_fetch(16'h0000, 0, 2, 0);

        check("sb_drained", 16'(sb.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage, directly upstream of the execute stage.
- Holds the architectural PC and fetches one 16-bit instruction per PC through a stallable instruction-memory handshake.
- Presents the instruction and its PC (PC_old) to decode/execute.
- Loads the next PC from execute's PC_curr output when execute retires the instruction.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INST, 16'h0800, instruction word driven on inst when no valid instruction is held.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- PC_next  in  16  next PC from execute (its PC_curr).
- pc_load  in  1  execute has retired the held instruction; PC_next is valid.
- stall  in  1  downstream hazard; blocks pc_load.
- halt  in  1  held instruction decoded as HALT.
- imem_req  out  1  instruction-memory read request.
- imem_addr  out  16  read address (equals the PC).
- imem_stall  in  1  memory busy; request not accepted this cycle.
- imem_done  in  1  read data valid on imem_rdata this cycle.
- imem_rdata  in  16  instruction word from memory.
- inst  out  16  held instruction.
- PC_old  out  16  PC of the held instruction.
- inst_valid  out  1  inst and PC_old are valid.
- inst_count  out  16  count of retired instructions.
- halted  out  1  fetch stopped by HALT.
- err  out  1  sticky error: misaligned PC.

Behaviour:
- Reset, asynchronous on rst high:
  - state=IDLE, PC=RESET_PC, inst=NOP_INST, inst_valid=0.
  - imem_req=0, inst_count=0, halted=0, err=0.
- All outputs are registered, except imem_req and imem_addr, which are decoded from state and PC.
- PC_old always equals the PC register.
- States:
  - IDLE: imem_req=0. Next state is REQ unconditionally (first request one cycle after reset release).
  - REQ: imem_req=1, imem_addr=PC.
    - imem_stall=1: stay in REQ; request and address held stable.
    - imem_stall=0: request accepted; go to WAIT.
  - WAIT: imem_req=0.
    - On imem_done=1: inst<=imem_rdata, inst_valid<=1, go to HOLD.
    - Otherwise stay in WAIT; no timeout.
  - HOLD: inst_valid=1; inst and PC_old stable.
    - halt=1 (priority over pc_load): halted<=1, inst_valid<=0, go to HALTED.
    - pc_load=1 and stall=0, with PC_next[0]=0:
      - PC<=PC_next, inst_valid<=0, inst<=NOP_INST.
      - inst_count<=inst_count+1, wrapping 16'hFFFF to 16'h0000.
      - Go to REQ.
    - pc_load=1 and stall=0, with PC_next[0]=1: err<=1, inst_valid<=0, go to ERROR; PC and inst_count unchanged.
    - pc_load=1 with stall=1: no change; stay in HOLD.
  - HALTED: absorbing until rst. imem_req=0, halted=1, inst=NOP_INST.
  - ERROR: absorbing until rst. imem_req=0, err=1.
- imem_done outside WAIT is ignored. This covers stray responses after reset mid-transaction.
- pc_load outside HOLD is ignored.
- The PC is only ever written with even values. Any even PC_next is accepted; 16'hFFFE followed by 16'h0000 is legal wrap-around computed by execute.
- Minimum latency:
  - 3 cycles from entering REQ to inst_valid=1, when imem_stall=0 and imem_done arrives on the first WAIT cycle.
  - Each imem_stall cycle and each WAIT cycle without imem_done adds one cycle.
- Reset mid-operation: any state returns to IDLE immediately (asynchronous); the outstanding request is abandoned.

Decomposition:
- Shared package fetch_pkg holds:
  - state encoding: IDLE, REQ, WAIT, HOLD, HALTED, ERROR, 3-bit.
  - NOP_INST constant.
  - default RESET_PC.
- One sub-module: pc_reg.
  - 16-bit register with asynchronous active-high reset to a parameterised value and a load enable.
  - Instantiated for PC, inst and inst_count.

Test Plan:
- Reset release, zero-wait memory:
  - imem_req=1 and imem_addr=16'h0000 on cycle 1.
  - imem_rdata=16'h4123 returned on cycle 2 gives inst=16'h4123, PC_old=0, inst_valid=1 on cycle 3.
- Retire:
  - In HOLD, pc_load=1, PC_next=16'h0002 gives imem_addr=16'h0002 with imem_req=1 next cycle, and inst_count=1.
- Stalls:
  - imem_stall=1 for 3 cycles in REQ holds imem_req=1 and imem_addr constant.
  - imem_done delayed 4 cycles in WAIT keeps inst_valid=0.
  - Correct instruction is captured afterwards.
- Priority and hold:
  - In HOLD, pc_load=1 with stall=1 for 2 cycles leaves PC and inst unchanged.
  - halt=1 together with pc_load=1 gives halted=1 and no further imem_req.
- Misaligned PC and wrap:
  - PC_next=16'h0013 gives err=1 and imem_req=0 thereafter.
  - PC_next=16'hFFFE, then 16'h0000, fetches normally.
  - After 65536 retires, inst_count wraps to 0.
- Reset mid-operation:
  - Assert rst while in WAIT; PC returns to RESET_PC and inst_valid=0 immediately.
  - A stray imem_done after rst release does not set inst_valid.
